// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the memory stage: icodes, controller states,
// and the decoded memory-operation record.
package y86_pkg;

  localparam logic [3:0] IRMMOVQ = 4'd4;
  localparam logic [3:0] IMRMOVQ = 4'd5;
  localparam logic [3:0] ICALL   = 4'd8;
  localparam logic [3:0] IRET    = 4'd9;
  localparam logic [3:0] IPUSHQ  = 4'd10;
  localparam logic [3:0] IPOPQ   = 4'd11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic        is_mem;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } mem_op_t;

endpackage

// File: rtl/mem_op_decode.sv
// Combinational decode of a memory-stage instruction into its data-memory
// operation: whether it touches memory, direction, full address and write data.
module mem_op_decode
  import y86_pkg::*;
(
  input  logic [3:0]  icode,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  output mem_op_t     op
);

  always_comb begin
    op = '0;
    unique case (icode)
      IRMMOVQ, IPUSHQ: op = '{is_mem: 1'b1, we: 1'b1, addr: valE, wdata: valA};
      ICALL:           op = '{is_mem: 1'b1, we: 1'b1, addr: valE, wdata: valP};
      IMRMOVQ:         op = '{is_mem: 1'b1, we: 1'b0, addr: valE, wdata: '0};
      IRET, IPOPQ:     op = '{is_mem: 1'b1, we: 1'b0, addr: valA, wdata: '0};
      default:         op = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage initiator: decodes the op, drives a multi-cycle req/ack data
// memory with timeout, and hands valM/dmem_error to write-back via valid/ready.
module mem_access_ctrl
  import y86_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [63:0]       valE,
  input  logic [63:0]       valA,
  input  logic [63:0]       valP,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       valM,
  output logic              dmem_error,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [63:0]       mem_rdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  mem_state_t        state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              in_ready_n, out_valid_n, err_n, req_n, we_n;
  logic [63:0]       valM_n, wdata_n;
  logic [ADDR_W-1:0] addr_n;
  mem_op_t           op;
  logic              addr_bad;

  mem_op_decode u_decode (
    .icode (icode),
    .valE  (valE),
    .valA  (valA),
    .valP  (valP),
    .op    (op)
  );

  // Range check uses the full 64-bit address, not the truncated word index.
  assign addr_bad = (op.addr >= 64'(MEM_WORDS));

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    in_ready_n  = in_ready;
    out_valid_n = out_valid;
    valM_n      = valM;
    err_n       = dmem_error;
    req_n       = mem_req;
    we_n        = mem_we;
    addr_n      = mem_addr;
    wdata_n     = mem_wdata;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          in_ready_n = 1'b0;
          if (!op.is_mem || addr_bad) begin
            state_n     = RESP;
            out_valid_n = 1'b1;
            valM_n      = '0;
            err_n       = op.is_mem;
          end else begin
            state_n = REQ;
            cnt_n   = '0;
            req_n   = 1'b1;
            we_n    = op.we;
            addr_n  = op.addr[ADDR_W-1:0];
            wdata_n = op.wdata;
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_n     = RESP;
          req_n       = 1'b0;
          out_valid_n = 1'b1;
          valM_n      = mem_we ? '0 : mem_rdata;
          err_n       = 1'b0;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          state_n     = RESP;
          req_n       = 1'b0;
          out_valid_n = 1'b1;
          valM_n      = '0;
          err_n       = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RESP: begin
        if (out_ready) begin
          state_n     = IDLE;
          out_valid_n = 1'b0;
          in_ready_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      valM       <= '0;
      dmem_error <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      in_ready   <= in_ready_n;
      out_valid  <= out_valid_n;
      valM       <= valM_n;
      dmem_error <= err_n;
      mem_req    <= req_n;
      mem_we     <= we_n;
      mem_addr   <= addr_n;
      mem_wdata  <= wdata_n;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: vector table of single transactions plus
// hand-written stall and reset-abort sequences.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode;
  logic [63:0] valE, valA, valP;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] valM;
  logic        dmem_error;
  logic        mem_req;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(10), .MEM_WORDS(1024), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .icode      (icode),
    .valE       (valE),
    .valA       (valA),
    .valP       (valP),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .valM       (valM),
    .dmem_error (dmem_error),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  typedef struct {
    string       name;
    logic [3:0]  icode;
    logic [63:0] valE, valA, valP;
    int          ack_at;     // REQ cycle on which memory acks; 0 = never
    logic [63:0] rdata;
    int          exp_req;    // expected number of REQ cycles
    logic        exp_we;
    logic [9:0]  exp_addr;
    logic [63:0] exp_wdata;
    logic [63:0] exp_valM;
    logic        exp_err;
    int          exp_lat;    // cycles from acceptance edge to out_valid
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input vec_t v);
    int lat;
    int req_cycles;
    icode = v.icode; valE = v.valE; valA = v.valA; valP = v.valP;
    in_valid = 1'b1;
    chk({v.name, ".in_ready_idle"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    icode = 4'h0; valE = '0; valA = '0; valP = '0;
    chk({v.name, ".in_ready_busy"}, in_ready, 0);
    lat = 1;
    req_cycles = 0;
    while (!out_valid && lat < 40) begin
      if (mem_req) begin
        req_cycles++;
        chk({v.name, ".we"}, mem_we, v.exp_we);
        chk({v.name, ".addr"}, mem_addr, v.exp_addr);
        chk({v.name, ".wdata"}, mem_wdata, v.exp_wdata);
        mem_ack   = (req_cycles == v.ack_at);
        mem_rdata = v.rdata;
      end
      step();
      mem_ack = 1'b0;
      mem_rdata = '0;
      lat++;
    end
    chk({v.name, ".latency"}, lat, v.exp_lat);
    chk({v.name, ".req_cycles"}, req_cycles, v.exp_req);
    chk({v.name, ".out_valid"}, out_valid, 1);
    chk({v.name, ".valM"}, valM, v.exp_valM);
    chk({v.name, ".dmem_error"}, dmem_error, v.exp_err);
    chk({v.name, ".req_dropped"}, mem_req, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({v.name, ".out_valid_clr"}, out_valid, 0);
    chk({v.name, ".in_ready_back"}, in_ready, 1);
  endtask

  vec_t vecs[$];

  initial begin
    rst = 1'b1; in_valid = 1'b0; icode = '0; valE = '0; valA = '0; valP = '0;
    out_ready = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    step(); step();
    rst = 1'b0;
    chk("rst.in_ready", in_ready, 1);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.valM", valM, 0);
    chk("rst.err", dmem_error, 0);
    chk("rst.mem_req", mem_req, 0);
    chk("rst.mem_we", mem_we, 0);
    chk("rst.mem_addr", mem_addr, 0);
    chk("rst.mem_wdata", mem_wdata, 0);

    vecs.push_back('{"rmmovq",  4'd4,  64'd5,    64'hABCD, 64'd0,    1,  64'd0,    1,  1'b1, 10'd5,    64'hABCD, 64'd0,    1'b0, 2});
    vecs.push_back('{"popq",    4'd11, 64'd0,    64'd7,    64'd0,    3,  64'h1234, 3,  1'b0, 10'd7,    64'd0,    64'h1234, 1'b0, 4});
    vecs.push_back('{"mr_oob",  4'd5,  64'd1024, 64'd0,    64'd0,    0,  64'd0,    0,  1'b0, 10'd0,    64'd0,    64'd0,    1'b1, 1});
    vecs.push_back('{"call_to", 4'd8,  64'd3,    64'd0,    64'h40,   0,  64'd0,    16, 1'b1, 10'd3,    64'h40,   64'd0,    1'b1, 17});
    vecs.push_back('{"ret_max", 4'd9,  64'd0,    64'd1023, 64'd0,    1,  64'hDEAD, 1,  1'b0, 10'd1023, 64'd0,    64'hDEAD, 1'b0, 2});
    vecs.push_back('{"pushq",   4'd10, 64'd200,  64'd55,   64'd0,    2,  64'h99,   2,  1'b1, 10'd200,  64'd55,   64'd0,    1'b0, 3});
    vecs.push_back('{"nop",     4'd0,  64'd9,    64'd9,    64'd9,    0,  64'd0,    0,  1'b0, 10'd0,    64'd0,    64'd0,    1'b0, 1});
    vecs.push_back('{"pop_hi",  4'd11, 64'd0,    64'h8000_0000_0000_0005, 64'd0, 1, 64'd1, 0, 1'b0, 10'd0, 64'd0, 64'd0, 1'b1, 1});
    vecs.push_back('{"ack_last",4'd5,  64'd20,   64'd0,    64'd0,    16, 64'hCAFE, 16, 1'b0, 10'd20,   64'd0,    64'hCAFE, 1'b0, 17});

    foreach (vecs[i]) run(vecs[i]);

    // Non-memory op held in RESP by back-pressure.
    icode = 4'd6; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall.out_valid", out_valid, 1);
      chk("stall.valM", valM, 0);
      chk("stall.in_ready", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("stall.out_valid_clr", out_valid, 0);
    chk("stall.in_ready_back", in_ready, 1);

    // Reset while a read is outstanding.
    icode = 4'd5; valE = 64'd9; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("abort.req_before", mem_req, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort.mem_req", mem_req, 0);
    chk("abort.in_ready", in_ready, 1);
    chk("abort.out_valid", out_valid, 0);
    mem_ack = 1'b1; mem_rdata = 64'h5555;
    step();
    mem_ack = 1'b0;
    step();
    chk("abort.late_ack_valid", out_valid, 0);
    chk("abort.late_ack_req", mem_req, 0);
    chk("abort.late_ack_ready", in_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Memory-stage initiator for the Y86-64 datapath. It takes the stage's icode/valE/valA/valP, decides whether the instruction reads or writes data memory, and drives a multi-cycle word-addressed data memory over a req/ack handshake. It returns valM and an error flag to the write-back side through a valid/ready handshake, and stalls upstream while an access is outstanding. It sits between execute and write-back and replaces direct combinational array access.

Parameters:
ADDR_W, 10, width of mem_addr; word index into data memory
MEM_WORDS, 1024, number of valid words; any index >= MEM_WORDS is an address error
TIMEOUT, 16, maximum cycles in REQ without mem_ack before the access is aborted

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  upstream holds an instruction
in_ready  output  1  controller can accept (high only in IDLE)
icode  input  4  instruction code
valE  input  64  ALU result / address
valA  input  64  register operand / stack address
valP  input  64  next PC
out_valid  output  1  result available
out_ready  input  1  downstream accepts result
valM  output  64  read data, 0 for non-read ops
dmem_error  output  1  address-range or timeout error for this instruction
mem_req  output  1  memory request, level held until ack
mem_we  output  1  1 = write, 0 = read
mem_addr  output  ADDR_W  word index
mem_wdata  output  64  write data
mem_ack  input  1  memory completes the request this cycle
mem_rdata  input  64  read data, valid with mem_ack when mem_we = 0

Behaviour:
- Op decode: 4 rmmovq writes valA to [valE]. 5 mrmovq reads [valE]. 8 call writes valP to [valE]. 9 ret reads [valA]. 10 pushq writes valA to [valE]. 11 popq reads [valA]. All other icodes have no memory op.
- FSM states: IDLE, REQ, RESP. Reset sets the state to IDLE. All outputs are registered. At reset: in_ready=1, out_valid=0, valM=0, dmem_error=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, and the timeout counter is 0.
- IDLE: in_ready=1. On in_valid the controller latches the op.
  - Non-memory op: go to RESP with valM=0 and error=0.
  - Memory op whose full 64-bit address is >= MEM_WORDS: go to RESP with valM=0 and error=1. No mem_req is issued.
  - Otherwise: go to REQ. mem_req, mem_we, mem_addr (low ADDR_W bits) and mem_wdata are driven from the next cycle.
- REQ: mem_req=1 and all request fields stay stable. The counter increments each cycle.
  - mem_ack=1: drop mem_req on the next edge and go to RESP. A read captures mem_rdata into valM. A write sets valM=0. Error=0.
  - Counter reaches TIMEOUT-1 without ack: drop mem_req, go to RESP, valM=0, error=1.
  - Ack and timeout in the same cycle: ack wins.
- RESP: out_valid=1 and valM/dmem_error are held until out_ready=1. On that edge out_valid goes to 0 and the state returns to IDLE. The controller can accept a new input no earlier than the cycle after.
- Latency from acceptance edge N:
  - Non-memory or error op: out_valid at N+1.
  - Memory op with ack on its first REQ cycle: out_valid at N+2.
  - Memory op in general: N+1+k, where k is the number of REQ cycles.
- mem_ack outside REQ is ignored. in_valid outside IDLE is ignored because in_ready=0.
- rst in any state returns to IDLE on that edge. An outstanding request is abandoned with mem_req=0 and no response is produced.
- The counter clears on entry to REQ and does not wrap, since exit happens at TIMEOUT-1.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants: IRMMOVQ=4, IMRMOVQ=5, ICALL=8, IRET=9, IPUSHQ=10, IPOPQ=11.
  - FSM state enum {IDLE, REQ, RESP}.
  - A mem_op struct {is_mem, we, addr, wdata}.
- One combinational sub-module, mem_op_decode, maps icode/valE/valA/valP to mem_op. The FSM lives in mem_access_ctrl.

Test Plan:
- Reset, then icode=4, valE=5, valA=0xABCD, memory acks on the first REQ cycle -> mem_req=1, we=1, addr=5, wdata=0xABCD. out_valid two cycles after acceptance with valM=0, error=0.
- icode=11, valA=7, memory acks after 3 REQ cycles with rdata=0x1234 -> mem_req held for exactly 3 cycles, we=0, addr=7. valM=0x1234, out_valid at acceptance+4.
- icode=5, valE=1024 -> no mem_req. Next cycle out_valid=1, dmem_error=1, valM=0.
- icode=8, valE=3, valP=0x40, memory never acks, TIMEOUT=16 -> mem_req high for 16 cycles then drops. dmem_error=1, valM=0.
- icode=6 with out_ready held 0 for 5 cycles -> out_valid and valM=0 held stable, in_ready=0 throughout. Returns to IDLE one edge after out_ready rises.
- Read in REQ, rst pulsed for 1 cycle -> next edge mem_req=0, in_ready=1, out_valid=0. A later mem_ack is ignored.
